gpi_debounce: RTL

//  Conditions raw push-button/switch pins before they reach the demo system's gp_i.
//  Per channel: synchronises to clk_i, debounces with a cycle counter, and emits one-cycle rise/fall event pulses.

---
 rtl/gpi_debounce_pkg.sv | 11 +
 rtl/gpi_debounce_chan.sv | 100 ++++++++++
 rtl/gpi_debounce.sv | 45 ++++
 3 files changed

// File: rtl/gpi_debounce_pkg.sv
// Shared types and helpers for the general-purpose input debouncer.
package gpi_debounce_pkg;

  typedef enum logic {DbIdle, DbPend} db_state_e;

  // Number of clock cycles that make up the requested stable time.
  function automatic int db_cnt_max(input int freq, input int us);
    return (freq / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/gpi_debounce_chan.sv
// One input channel: synchroniser chain, stability counter/FSM and edge pulses.
module gpi_debounce_chan
  import gpi_debounce_pkg::*;
#(
  parameter int   CntMax     = 1,
  parameter int   SyncStages = 2,
  parameter logic ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic bypass_i,
  output logic gp_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] CntMaxV = CntW'(CntMax);

  logic [SyncStages-1:0] sync_reg;
  logic                  s;
  logic                  d;

  db_state_e             state_reg, state_next;
  logic [CntW-1:0]       cnt_reg, cnt_next;
  logic                  gp_reg, gp_next;
  logic                  rise_reg, rise_next;
  logic                  fall_reg, fall_next;

  assign s = sync_reg[SyncStages-1];
  assign d = (s != gp_reg);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_reg  <= {SyncStages{ResetValue}};
      state_reg <= DbIdle;
      cnt_reg   <= '0;
      gp_reg    <= ResetValue;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SyncStages-2:0], raw_i};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      gp_reg    <= gp_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gp_next    = gp_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    if (bypass_i) begin
      // Follow the synchronised pin directly; pulses still mark each change.
      state_next = DbIdle;
      cnt_next   = '0;
      gp_next    = s;
      rise_next  = s & ~gp_reg;
      fall_next  = ~s & gp_reg;
    end else begin
      unique case (state_reg)
        DbIdle: begin
          cnt_next = '0;
          if (d) begin
            state_next = DbPend;
            cnt_next   = CntW'(1);
          end
        end
        DbPend: begin
          if (!d) begin
            state_next = DbIdle;
            cnt_next   = '0;
          end else if (cnt_reg == CntMaxV) begin
            state_next = DbIdle;
            cnt_next   = '0;
            gp_next    = ~gp_reg;
            rise_next  = ~gp_reg;
            fall_next  = gp_reg;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = DbIdle;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign gp_o   = gp_reg;
  assign rise_o = rise_reg;
  assign fall_o = fall_reg;

endmodule

// File: rtl/gpi_debounce.sv
// Debounced GPIO input block: one independent conditioning channel per pin.
module gpi_debounce
  import gpi_debounce_pkg::*;
#(
  parameter int                  GpiWidth       = 8,
  parameter int                  ClockFrequency = 50_000_000,
  parameter int                  DebounceUs     = 10_000,
  parameter int                  SyncStages     = 2,
  parameter logic [GpiWidth-1:0] ResetValue     = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [GpiWidth-1:0] raw_i,
  input  logic                bypass_i,
  output logic [GpiWidth-1:0] gp_o,
  output logic [GpiWidth-1:0] rise_o,
  output logic [GpiWidth-1:0] fall_o
);

  localparam int CntMax = db_cnt_max(ClockFrequency, DebounceUs);

  if (CntMax < 1) begin : g_bad_cnt_max
    $error("gpi_debounce: debounce time shorter than one clock cycle");
  end
  if (SyncStages < 2) begin : g_bad_sync_stages
    $error("gpi_debounce: at least two synchroniser stages are needed");
  end

  for (genvar gi = 0; gi < GpiWidth; gi++) begin : g_chan
    gpi_debounce_chan #(
      .CntMax     (CntMax),
      .SyncStages (SyncStages),
      .ResetValue (ResetValue[gi])
    ) u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .raw_i    (raw_i[gi]),
      .bypass_i (bypass_i),
      .gp_o     (gp_o[gi]),
      .rise_o   (rise_o[gi]),
      .fall_o   (fall_o[gi])
    );
  end

endmodule
